// File: rtl/uart_pkg.sv
// Shared constants for the 8051-style serial port: mode encodings, default
// oversample rate and the config-handshake state type.
package uart_pkg;

  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_UART8  = 2'd1;
  localparam logic [1:0] MODE_UART9F = 2'd2;
  localparam logic [1:0] MODE_UART9V = 2'd3;

  localparam int OS_RATE_DEF = 16;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/uart_tick_prescaler.sv
// Enable-gated modulo-(i_last+1) counter with a combinational wrap strobe and a
// registered wrap pulse one cycle later; i_clr restarts it from zero.
module uart_tick_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic         o_wrap,
  output logic         o_pulse
);

  logic [W-1:0] r_cnt;
  logic         r_pulse;

  // >= keeps the count inside the modulus even if i_last ever shrinks
  assign o_wrap  = i_en & (r_cnt >= i_last);
  assign o_pulse = r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= o_wrap;
      if (o_wrap)
        r_cnt <= '0;
      else if (i_en)
        r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_mode_clock_ctrl.sv
// Baud/tick scheduler for the 4-mode serial port: picks the tick source per mode,
// applies SMOD, and defers config changes until both tx and rx are idle.
module uart_mode_clock_ctrl
  import uart_pkg::*;
#(
  parameter int M0_DIV    = 12,
  parameter int M2_OS_DIV = 4,
  parameter int OS_RATE   = OS_RATE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cfg_wr,
  input  logic [1:0] i_cfg_mode,
  input  logic       i_cfg_smod,
  input  logic       i_t1_ovf,
  input  logic       i_tx_busy,
  input  logic       i_rx_busy,
  output logic       o_cfg_ack,
  output logic [1:0] o_active_mode,
  output logic       o_active_smod,
  output logic       o_cfg_pending,
  output logic       o_tick16,
  output logic       o_tx_bit_tick
);

  localparam int PRE_MAX = (M0_DIV > M2_OS_DIV) ? M0_DIV : M2_OS_DIV;
  localparam int PW      = $clog2(PRE_MAX);
  localparam int OW      = $clog2(OS_RATE);

  cfg_state_e r_state, w_state_nxt;
  logic [1:0] r_pend_mode, r_mode;
  logic       r_pend_smod, r_smod, r_ack;
  logic       w_apply;

  always_comb begin
    w_apply     = ((r_state == CFG_PEND) | i_cfg_wr) & ~i_tx_busy & ~i_rx_busy;
    w_state_nxt = r_state;
    if (w_apply)
      w_state_nxt = CFG_IDLE;
    else if (i_cfg_wr)
      w_state_nxt = CFG_PEND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CFG_IDLE;
      r_pend_mode <= MODE_SHIFT;
      r_pend_smod <= 1'b0;
      r_mode      <= MODE_SHIFT;
      r_smod      <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_apply;
      if (i_cfg_wr) begin
        r_pend_mode <= i_cfg_mode;
        r_pend_smod <= i_cfg_smod;
      end
      // a same-cycle write supersedes whatever was already pending
      if (w_apply) begin
        r_mode <= i_cfg_wr ? i_cfg_mode : r_pend_mode;
        r_smod <= i_cfg_wr ? i_cfg_smod : r_pend_smod;
      end
    end
  end

  logic [PW-1:0] w_pre_last;
  logic          w_pre_en, w_pre_wrap, w_pre_pulse;
  logic          w_os_wrap, w_os_pulse;

  always_comb begin
    w_pre_last = PW'(M0_DIV - 1);
    w_pre_en   = 1'b1;
    case (r_mode)
      MODE_SHIFT:  w_pre_last = PW'(M0_DIV - 1);
      MODE_UART9F: w_pre_last = r_smod ? PW'(M2_OS_DIV / 2 - 1) : PW'(M2_OS_DIV - 1);
      default: begin
        w_pre_en   = i_t1_ovf;
        w_pre_last = r_smod ? PW'(0) : PW'(1);
      end
    endcase
  end

  uart_tick_prescaler #(.W(PW)) u_pre (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_apply),
    .i_en    (w_pre_en),
    .i_last  (w_pre_last),
    .o_wrap  (w_pre_wrap),
    .o_pulse (w_pre_pulse)
  );

  // counts on the prescaler wrap edge so its pulse lines up with tick16
  uart_tick_prescaler #(.W(OW)) u_os (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_apply),
    .i_en    (w_pre_wrap & (r_mode != MODE_SHIFT)),
    .i_last  (OW'(OS_RATE - 1)),
    .o_wrap  (w_os_wrap),
    .o_pulse (w_os_pulse)
  );

  assign o_cfg_ack     = r_ack;
  assign o_active_mode = r_mode;
  assign o_active_smod = r_smod;
  assign o_cfg_pending = (r_state == CFG_PEND);
  assign o_tick16      = w_pre_pulse;
  assign o_tx_bit_tick = (r_mode == MODE_SHIFT) ? w_pre_pulse : w_os_pulse;

endmodule

// File: tb/tb_uart_mode_clock_ctrl.sv
// Self-checking bench for uart_mode_clock_ctrl: event-count reference model
// compared every cycle, plus directed period and handshake checks.
module tb_uart_mode_clock_ctrl;

  localparam int M0 = 12, M2 = 4, OS = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       i_cfg_wr = 1'b0, i_cfg_smod = 1'b0, i_t1_ovf = 1'b0;
  logic [1:0] i_cfg_mode = 2'd0;
  logic       i_tx_busy = 1'b0, i_rx_busy = 1'b0;
  logic       o_cfg_ack, o_active_smod, o_cfg_pending, o_tick16, o_tx_bit_tick;
  logic [1:0] o_active_mode;

  uart_mode_clock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_wr(i_cfg_wr), .i_cfg_mode(i_cfg_mode),
    .i_cfg_smod(i_cfg_smod), .i_t1_ovf(i_t1_ovf), .i_tx_busy(i_tx_busy),
    .i_rx_busy(i_rx_busy), .o_cfg_ack(o_cfg_ack), .o_active_mode(o_active_mode),
    .o_active_smod(o_active_smod), .o_cfg_pending(o_cfg_pending),
    .o_tick16(o_tick16), .o_tx_bit_tick(o_tx_bit_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, ack_cnt = 0, t16_cnt = 0;
  int ovf_period = 0, k = 0;
  bit ovf_manual = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    #1;
    k++;
    i_t1_ovf = ovf_manual || (ovf_period != 0 && (k % ovf_period) == 0);
  end

  // Reference model: count source events since the last apply; ticks fall on multiples of D.
  int m_mode = 0, m_smod = 0, m_pmode = 0, m_psmod = 0, m_n = 0;
  bit m_pend = 0, m_ack = 0, m_t16 = 0, m_tx = 0;

  function automatic int div_of(input int md, input int sm);
    if (md == 0) return M0;
    if (md == 2) return sm ? M2 / 2 : M2;
    return sm ? 1 : 2;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_smod = 0; m_pmode = 0; m_psmod = 0; m_n = 0;
      m_pend = 0; m_ack = 0; m_t16 = 0; m_tx = 0;
    end else if ((m_pend || i_cfg_wr) && !i_tx_busy && !i_rx_busy) begin
      m_mode = i_cfg_wr ? int'(i_cfg_mode) : m_pmode;
      m_smod = i_cfg_wr ? int'(i_cfg_smod) : m_psmod;
      m_pend = 0; m_ack = 1; m_n = 0; m_t16 = 0; m_tx = 0;
    end else begin
      m_ack = 0;
      if (i_cfg_wr) begin
        m_pmode = int'(i_cfg_mode); m_psmod = int'(i_cfg_smod); m_pend = 1;
      end
      if (m_mode == 0 || m_mode == 2 || i_t1_ovf) begin
        m_n++;
        m_t16 = (m_n % div_of(m_mode, m_smod)) == 0;
        m_tx  = (m_mode == 0) ? m_t16 : ((m_n % (div_of(m_mode, m_smod) * OS)) == 0);
      end else begin
        m_t16 = 0; m_tx = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cfg_ack", int'(o_cfg_ack), int'(m_ack));
    check("active_mode", int'(o_active_mode), m_mode);
    check("active_smod", int'(o_active_smod), m_smod);
    check("cfg_pending", int'(o_cfg_pending), int'(m_pend));
    check("tick16", int'(o_tick16), int'(m_t16));
    check("tx_bit_tick", int'(o_tx_bit_tick), int'(m_tx));
    if (o_cfg_ack) ack_cnt++;
    if (o_tick16) t16_cnt++;
  end

  task automatic wait_tick(input bit tx, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx ? o_tx_bit_tick : o_tick16) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic period(input string nm, input bit tx, input int budget, input int exp);
    int a, b;
    wait_tick(tx, budget, a);
    wait_tick(tx, budget, b);
    check(nm, (a < 0 || b < 0) ? -1 : b - a, exp);
  endtask

  task automatic do_cfg(input logic [1:0] md, input logic sm);
    @(negedge clk);
    i_cfg_wr = 1'b1; i_cfg_mode = md; i_cfg_smod = sm;
    @(negedge clk);
    i_cfg_wr = 1'b0;
  endtask

  initial begin
    int c0, c1, a0, t0;
    repeat (3) @(negedge clk);
    check("reset mode", int'(o_active_mode), 0);
    check("reset pending", int'(o_cfg_pending), 0);
    check("reset ticks", int'({o_tick16, o_tx_bit_tick, o_cfg_ack}), 0);
    #1 rst_n = 1'b1;

    // 1: mode 0 idle config, ack next cycle, first bit tick 12 clk after apply
    do_cfg(2'd0, 1'b0);
    c0 = cyc;
    check("t1 ack next cycle", int'(o_cfg_ack), 1);
    check("t1 no pending", int'(o_cfg_pending), 0);
    wait_tick(1'b1, 40, c1);
    check("t1 first tx tick", (c1 < 0) ? -1 : c1 - c0, 12);
    period("t1 tx period", 1'b1, 40, 12);

    // 2: mode 2, then SMOD doubling
    do_cfg(2'd2, 1'b0);
    period("t2 tick16 smod0", 1'b0, 20, 4);
    period("t2 tx smod0", 1'b1, 200, 64);
    do_cfg(2'd2, 1'b1);
    period("t2 tick16 smod1", 1'b0, 20, 2);
    period("t2 tx smod1", 1'b1, 200, 32);

    // 3: mode 1 on Timer-1 overflow every 10 clk
    ovf_period = 10;
    do_cfg(2'd1, 1'b0);
    period("t3 tick16 smod0", 1'b0, 100, 20);
    period("t3 tx smod0", 1'b1, 800, 320);
    do_cfg(2'd1, 1'b1);
    period("t3 tick16 smod1", 1'b0, 100, 10);
    period("t3 tx smod1", 1'b1, 400, 160);
    ovf_period = 0;
    repeat (3) @(negedge clk);
    #1 t0 = t16_cnt;
    repeat (100) @(negedge clk);
    #1 check("t3 no ovf no ticks", t16_cnt - t0, 0);

    // 4: writes while busy stay pending (last wins), old rate continues
    ovf_period = 10;
    i_tx_busy = 1'b1;
    a0 = ack_cnt;
    do_cfg(2'd2, 1'b1);
    do_cfg(2'd3, 1'b0);
    check("t4 pending while busy", int'(o_cfg_pending), 1);
    period("t4 old tick16 rate", 1'b0, 100, 10);
    check("t4 no ack while busy", ack_cnt - a0, 0);
    @(negedge clk);
    i_tx_busy = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("t4 single ack", ack_cnt - a0, 1);
    check("t4 mode 3", int'(o_active_mode), 3);
    check("t4 smod last wins", int'(o_active_smod), 0);

    // 5: overflow on the apply edge is discarded
    ovf_period = 0;
    repeat (12) @(negedge clk);
    @(negedge clk);
    i_cfg_wr = 1'b1; i_cfg_mode = 2'd3; i_cfg_smod = 1'b0; ovf_manual = 1'b1;
    @(negedge clk);
    i_cfg_wr = 1'b0; ovf_manual = 1'b0;
    #1 t0 = t16_cnt;
    @(negedge clk); ovf_manual = 1'b1;
    @(negedge clk); ovf_manual = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("t5 first ovf no tick", t16_cnt - t0, 0);
    @(negedge clk); ovf_manual = 1'b1;
    @(negedge clk); ovf_manual = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("t5 second ovf tick", t16_cnt - t0, 1);

    // 6: async reset with a pending config
    ovf_period = 10;
    i_tx_busy = 1'b1;
    do_cfg(2'd2, 1'b0);
    repeat (15) @(negedge clk);
    check("t6 pre-reset pending", int'(o_cfg_pending), 1);
    check("t6 pre-reset mode", int'(o_active_mode), 3);
    #2 rst_n = 1'b0;
    #1 check("t6 async outputs zero",
             int'({o_cfg_ack, o_active_mode, o_active_smod, o_cfg_pending, o_tick16, o_tx_bit_tick}), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    i_tx_busy = 1'b0;
    a0 = ack_cnt;
    repeat (5) @(negedge clk);
    #1 check("t6 mode after reset", int'(o_active_mode), 0);
    check("t6 pending after reset", int'(o_cfg_pending), 0);
    check("t6 lost config not acked", ack_cnt - a0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
